// File: rtl/risc16_program_loader_pkg.sv
// Shared types and constants for the RiSC16 program loader.
package risc16_program_loader_pkg;

  localparam int DEFAULT_WORD_LENGTH = 16;
  localparam int HOLD_TIMER_WIDTH    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/risc16_program_loader_hold_timer.sv
// Down-counter that keeps the core in reset after a load; expire is a terminal-count compare.
module risc16_hold_timer
  import risc16_program_loader_pkg::*;
#(
  parameter int WIDTH = HOLD_TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             count,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] remaining;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_value;
    end else if (count && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
    end
  end

  assign expire = (remaining == '0);

endmodule

// File: rtl/risc16_program_loader.sv
// Streams a program into RiSC16 instruction memory, then releases the core from reset.
//  state | meaning
//  IDLE  | core held in reset, waiting for start
//  LOAD  | accepting instruction words, one per cycle
//  HOLD  | last word written, core kept in reset for RESET_CYCLES
//  RUN   | core executing the loaded program
module risc16_program_loader
  import risc16_program_loader_pkg::*;
#(
  parameter int WORD_LENGTH  = DEFAULT_WORD_LENGTH,
  parameter int RESET_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WORD_LENGTH-1:0] load_base,
  input  logic                   in_valid,
  input  logic [WORD_LENGTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   pen,
  output logic [WORD_LENGTH-1:0] addr,
  output logic [WORD_LENGTH-1:0] instr,
  output logic                   core_rst,
  output logic                   done,
  output logic                   error,
  output logic [WORD_LENGTH-1:0] word_count
);

  state_t                 state;
  logic [WORD_LENGTH-1:0] pointer;
  logic                   wrap;
  logic                   final_xfer;
  logic                   timer_load;
  logic                   timer_count;
  logic                   timer_expire;

  assign in_ready    = (state == ST_LOAD);
  assign wrap        = &pointer;
  assign final_xfer  = in_valid && (in_last || wrap);
  assign timer_load  = in_ready && !abort && final_xfer;
  assign timer_count = (state == ST_HOLD);

  risc16_hold_timer #(
    .WIDTH(HOLD_TIMER_WIDTH)
  ) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .count      (timer_count),
    .load_value (HOLD_TIMER_WIDTH'(RESET_CYCLES)),
    .expire     (timer_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pen        <= 1'b0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      addr       <= '0;
      instr      <= '0;
      word_count <= '0;
      pointer    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RUN: begin
          if (start) begin
            state      <= ST_LOAD;
            pointer    <= load_base;
            word_count <= '0;
            error      <= 1'b0;
            pen        <= 1'b1;
            core_rst   <= 1'b1;
            done       <= 1'b0;
          end
        end
        ST_LOAD: begin
          // abort wins over a word presented on the same edge
          if (abort) begin
            state    <= ST_IDLE;
            pen      <= 1'b0;
            core_rst <= 1'b1;
          end else if (in_valid) begin
            addr       <= pointer;
            instr      <= in_data;
            pointer    <= pointer + 1'b1;
            word_count <= word_count + 1'b1;
            if (final_xfer) begin
              state <= ST_HOLD;
              if (!in_last) begin
                error <= 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          // pen stays high through the first HOLD cycle so the last word lands
          pen <= 1'b0;
          if (timer_expire) begin
            state    <= ST_RUN;
            core_rst <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc16_program_loader.sv
// Scoreboard bench: stimulus predicts memory writes, a monitor checks each accepted word.
module tb_risc16_program_loader;

  localparam int W = 16;
  localparam int R = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] load_base = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic         pen;
  logic [W-1:0] addr;
  logic [W-1:0] instr;
  logic         core_rst;
  logic         done;
  logic         error;
  logic [W-1:0] word_count;

  risc16_program_loader #(
    .WORD_LENGTH  (W),
    .RESET_CYCLES (R)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .load_base  (load_base),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .pen        (pen),
    .addr       (addr),
    .instr      (instr),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] d;
    logic [W-1:0] c;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  bit           xfer = 1'b0;
  logic [W-1:0] wdata[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshake as seen on the edge; state changes by NBA so in_ready is the pre-edge value.
  always @(posedge clk) xfer = in_valid && in_ready && !abort && !rst;

  always @(negedge clk) begin
    exp_t e;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h instr=%0h expected no write", addr, instr);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", addr, e.a);
        chk("write_instr", instr, e.d);
        chk("write_count", word_count, e.c);
        chk("write_pen", pen, 1);
      end
    end
  end

  task automatic do_session(input logic [W-1:0] base, input int n, input bit use_last,
                            input int abort_idx, input bit gaps);
    int           acc;
    logic [W-1:0] ptr;
    bit           ended;
    bit           exp_err;
    exp_t         e;
    @(negedge clk);
    start = 1'b1; load_base = base; abort = 1'b0;
    @(negedge clk);
    start = 1'b0; load_base = W'($urandom);
    chk("start_ready", in_ready, 1);
    chk("start_pen", pen, 1);
    chk("start_core_rst", core_rst, 1);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
    chk("start_count", word_count, 0);
    ptr = base; acc = 0; ended = 1'b0; exp_err = 1'b0;
    for (int i = 0; i < n && !ended; i++) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0; in_data = W'($urandom); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("gap_pen", pen, 1);
        chk("gap_count", word_count, W'(acc));
      end
      in_valid = 1'b1; in_data = wdata[i];
      in_last = use_last && (i == n - 1);
      abort = (i == abort_idx);
      if (abort) begin
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("abort_ready", in_ready, 0);
        chk("abort_pen", pen, 0);
        chk("abort_core_rst", core_rst, 1);
        chk("abort_done", done, 0);
        chk("abort_count", word_count, W'(acc));
        return;
      end
      e.a = ptr; e.d = wdata[i]; e.c = W'(acc + 1);
      exp_q.push_back(e);
      acc++;
      exp_err = !in_last && (ptr == {W{1'b1}});
      ended = in_last || (ptr == {W{1'b1}});
      ptr = ptr + 1'b1;
      @(negedge clk);
    end
    in_last = 1'b0;
    if (!ended) begin
      in_valid = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      return;
    end
    // HOLD: extra words, start and abort must all be ignored
    in_valid = 1'b1; in_data = W'($urandom); start = 1'b1; abort = 1'b1;
    chk("hold_pen_last", pen, 1);
    chk("hold_error", error, exp_err);
    chk("hold_core_rst0", core_rst, 1);
    chk("hold_ready", in_ready, 0);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("hold_pen_drop", pen, 0);
    for (int j = 1; j <= R; j++) begin
      chk("hold_core_rst", core_rst, 1);
      chk("hold_done", done, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("run_core_rst", core_rst, 0);
    chk("run_done", done, 1);
    chk("run_pen", pen, 0);
    chk("run_count", word_count, W'(acc));
    chk("run_error", error, exp_err);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("run_abort_ignored", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    exp_t e;
    repeat (6) @(negedge clk);
    chk("rst_pen", pen, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_addr", addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_count", word_count, 0);
    chk("rst_ready", in_ready, 0);
    rst = 1'b0;

    wdata[0] = 16'h6A00; wdata[1] = 16'h6D00; wdata[2] = 16'h0903;
    do_session(16'h0000, 3, 1'b1, 99, 1'b0);
    wdata[0] = 16'h0903;
    do_session(16'h0010, 1, 1'b1, 99, 1'b0);
    for (int i = 0; i < 8; i++) wdata[i] = W'($urandom);
    do_session(16'h0100, 5, 1'b1, 99, 1'b1);
    do_session(16'hFFFE, 3, 1'b0, 99, 1'b0);
    do_session(16'h0040, 3, 1'b1, 1, 1'b0);

    for (int s = 0; s < 25; s++) begin
      logic [W-1:0] b;
      int n;
      int ai;
      for (int i = 0; i < 8; i++) wdata[i] = W'($urandom);
      b = ($urandom_range(3, 0) == 0) ? (16'hFFFF - W'($urandom_range(4, 0))) : W'($urandom);
      n = $urandom_range(6, 1);
      ai = ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : 99;
      do_session(b, n, 1'b1, ai, $urandom_range(1, 0) == 1);
    end

    // asynchronous reset in the middle of HOLD
    @(negedge clk);
    start = 1'b1; load_base = 16'h0020;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b1;
    e.a = 16'h0020; e.d = 16'h1234; e.c = 16'h0001;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_pen", pen, 0);
    chk("arst_core_rst", core_rst, 1);
    chk("arst_done", done, 0);
    chk("arst_error", error, 0);
    chk("arst_addr", addr, 0);
    chk("arst_instr", instr, 0);
    chk("arst_count", word_count, 0);
    chk("arst_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (R + 3) @(negedge clk);
    chk("arst_no_run_done", done, 0);
    chk("arst_no_run_core_rst", core_rst, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
